instr_fetch_unit: RTL
=====================

Name: instr_fetch_unit

Overview:
Upstream neighbour of control_unit and aluControl_unit inside Proc. It holds the program counter and fetches 32-bit instructions from instruction memory over a req/ready handshake. It latches each instruction into an instruction register and splits it into the fields the decode logic consumes: op_code, func_code, register indices, shamt and imm. It holds its output under stall from later stages and redirects the PC on a taken branch.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
imem_req  output  1  fetch request to instruction memory
imem_addr  output  32  byte address of the fetch; always equal to pc
imem_ready  input  1  memory has imem_rdata valid this cycle
imem_rdata  input  32  instruction word from memory
stall  input  1  downstream cannot accept a new instruction; hold outputs
branch_taken  input  1  redirect the PC; honoured only in VALID state with stall=0
branch_target  input  32  redirect address; bits [1:0] ignored and treated as 0
instr_valid  output  1  instr and all decoded fields are valid
instr  output  32  instruction register contents
op_code  output  6  instr[31:26]
rs  output  5  instr[25:21]
rt  output  5  instr[20:16]
rd  output  5  instr[15:11]
shamt  output  5  instr[10:6]
func_code  output  6  instr[5:0]
imm  output  16  instr[15:0]
pc_out  output  32  address of the instruction currently in instr
pc_plus4  output  32  pc_out + 4, modulo 2^32
fetch_count  output  32  number of instructions accepted downstream

Behaviour:
- State machine with two states: REQ and VALID.
- Reset (synchronous, any state, mid-handshake included):
  - state=REQ, pc=RESET_PC, instr=0, pc_out=0, instr_valid=0, fetch_count=0.
  - Any memory response in flight is discarded.
  - Decoded fields are slices of instr, so they all read 0 after reset.
- REQ:
  - imem_req=1, imem_addr=pc, instr_valid=0.
  - While imem_ready=0: stay in REQ; pc and instr unchanged.
  - When imem_ready=1 at a clock edge: instr<=imem_rdata, pc_out<=pc, go to VALID.
  - stall and branch_taken are ignored in REQ.
- VALID:
  - imem_req=0, instr_valid=1; instr and pc_out held stable.
  - stall=1: remain in VALID; all outputs frozen; branch_taken ignored.
  - stall=0, branch_taken=0: pc<=pc_out+4, fetch_count++, go to REQ.
  - stall=0, branch_taken=1: pc<={branch_target[31:2],2'b00}, fetch_count++, go to REQ.
- Latency: the first imem_req is high in the cycle after reset deasserts. With imem_ready=1 in that same cycle, instr_valid rises one edge later. Best-case throughput is one instruction per 2 cycles.
- Arithmetic: pc increments wrap modulo 2^32, so 32'hFFFF_FFFC+4 = 0. fetch_count also wraps from 32'hFFFF_FFFF to 0.
- imem_addr[1:0] is always 2'b00.
- imem_rdata is sampled only in REQ when imem_ready=1; imem_ready in VALID is ignored.
- pc_plus4 is combinational from pc_out.

Test Plan:
1. Reset, then imem_ready=1 constantly, with the memory returning addr+32'h1000 -> imem_addr sequence 0,4,8; instr_valid alternates 0/1. At the first VALID: instr=32'h0000_1000, pc_out=0, pc_plus4=4. After 3 accepts, fetch_count=3.
2. imem_ready low for 3 cycles in REQ, then imem_rdata=32'h012A_4020 -> imem_req stays high 4 cycles with imem_addr fixed. Then op_code=0, rs=9, rt=10, rd=8, shamt=0, func_code=6'h20, imm=16'h4020.
3. stall=1 for 5 cycles in VALID with branch_taken=1 pulsed mid-stall -> outputs frozen and fetch_count unchanged. On release with branch_taken=0, next imem_addr=pc_out+4.
4. In VALID with stall=0, branch_taken=1 and branch_target=32'h0000_0103 -> next imem_addr=32'h0000_0100.
5. RESET_PC=32'hFFFF_FFFC -> the second fetch addresses 32'h0000_0000.
6. Assert reset in REQ while imem_ready=1 -> the next cycle shows instr_valid=0, instr=0, imem_addr=RESET_PC, fetch_count=0.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//   Holds the program counter and fetches one 32-bit instruction at a time
//   from instruction memory over a req/ready handshake. The fetched word is
//   held in an instruction register and split into decode fields. Downstream
//   stall freezes the outputs. A taken branch redirects the PC when the
//   current instruction is accepted.
//
// Ports
//   clk, reset        : clock; synchronous active-high reset
//   imem_req/addr     : fetch request and byte address (addr always == pc)
//   imem_ready/rdata  : memory response handshake and instruction word
//   stall             : downstream hold; instruction is not accepted
//   branch_taken/target : PC redirect, applied when the instruction is accepted
//   instr_valid, instr: instruction register and its valid flag
//   op_code..imm      : fixed bit slices of instr
//   pc_out, pc_plus4  : address of instr and that address + 4
//   fetch_count       : instructions accepted downstream (wraps)
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [5:0]  op_code,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [4:0]  shamt,
    output logic [5:0]  func_code,
    output logic [15:0] imm,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4,
    output logic [31:0] fetch_count
);

    typedef enum logic {
        S_REQ   = 1'b0,
        S_VALID = 1'b1
    } state_e;

    // Word alignment is forced here so a misaligned parameter cannot leak
    // onto imem_addr.
    localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_out_q, pc_out_d;
    logic [31:0] cnt_q, cnt_d;

    // Low target bits are architecturally ignored.
    logic unused_tgt_bits;
    assign unused_tgt_bits = ^branch_target[1:0];

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        pc_out_d = pc_out_q;
        cnt_d    = cnt_q;
        case (state_q)
            S_REQ: begin
                if (imem_ready) begin
                    instr_d  = imem_rdata;
                    pc_out_d = pc_q;
                    state_d  = S_VALID;
                end
            end
            S_VALID: begin
                // Acceptance happens only when downstream is not stalled;
                // a branch seen during a stall is dropped.
                if (!stall) begin
                    pc_d    = branch_taken ? {branch_target[31:2], 2'b00}
                                           : pc_out_q + 32'd4;
                    cnt_d   = cnt_q + 32'd1;
                    state_d = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_REQ;
            pc_q     <= RESET_PC_ALIGNED;
            instr_q  <= 32'h0;
            pc_out_q <= 32'h0;
            cnt_q    <= 32'h0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            pc_out_q <= pc_out_d;
            cnt_q    <= cnt_d;
        end
    end

    assign imem_req    = (state_q == S_REQ);
    assign imem_addr   = pc_q;
    assign instr_valid = (state_q == S_VALID);
    assign instr       = instr_q;
    assign op_code     = instr_q[31:26];
    assign rs          = instr_q[25:21];
    assign rt          = instr_q[20:16];
    assign rd          = instr_q[15:11];
    assign shamt       = instr_q[10:6];
    assign func_code   = instr_q[5:0];
    assign imm         = instr_q[15:0];
    assign pc_out      = pc_out_q;
    assign pc_plus4    = pc_out_q + 32'd4;
    assign fetch_count = cnt_q;

endmodule
